forward_selection_rdata: RTL
============================

// Module: forward_selection_rdata
// PURPOSE
// - Read-data return path of the dpsram_block_4x512x20 cascade. Counterpart of the forward address selection.
// - Routes RAM read data and read-valid back to the port that issued the address.
// - Sources are local x0/x1 RAM or the upper/lower cascade neighbour.
// - Tracks RAM read latency with a valid pipeline, adds an optional output register,
//   and flags config changes made while reads are in flight.
// PARAMETERS
// - DATA_W   20  read data width per port
// - RD_LAT   1   RAM read latency in cycles, legal range 1..4
// - OUT_REG  1   1: register x0/x1 outputs (+1 cycle); 0: combinational outputs
// PORTS
// - clk_i                 in   1       clock; all state on rising edge
// - rst_i                 in   1       asynchronous, active-high reset
// - cfg_forward_rdata_i   in   8       same encoding as cfg_forward_addr; quasi-static
// - x0_ram_re_i           in   1       read enable applied to x0 RAM port this cycle
// - x1_ram_re_i           in   1       read enable applied to x1 RAM port this cycle
// - x0_ram_rdata_i        in   DATA_W  x0 RAM read data (valid RD_LAT cycles after re)
// - x1_ram_rdata_i        in   DATA_W  x1 RAM read data
// - forward_rdata_up_i    in   DATA_W  data arriving from upper neighbour
// - forward_rvalid_up_i   in   1       valid for forward_rdata_up_i
// - forward_rdata_low_i   in   DATA_W  data arriving from lower neighbour
// - forward_rvalid_low_i  in   1       valid for forward_rdata_low_i
// - x0_rdata_o            out  DATA_W  read data returned to port x0
// - x0_rvalid_o           out  1       x0 read data valid
// - x1_rdata_o            out  DATA_W  read data returned to port x1
// - x1_rvalid_o           out  1       x1 read data valid
// - forward_rdata_up_o    out  DATA_W  data sent to upper neighbour
// - forward_rvalid_up_o   out  1       valid for forward_rdata_up_o
// - forward_rdata_low_o   out  DATA_W  data sent to lower neighbour
// - forward_rvalid_low_o  out  1       valid for forward_rdata_low_o
// - cfg_chg_err_o         out  1       sticky: cfg changed while a read was pending
// BEHAVIOUR
// - Reset (async, rst_i=1):
//   - valid pipelines, output registers, cfg shadow and cfg_chg_err_o cleared to 0.
//   - All rvalid outputs are 0; all rdata outputs are 0.
//   - In-flight reads are dropped.
// - Valid pipeline: x0_ram_re_i and x1_ram_re_i each enter an RD_LAT-deep shift register.
//   - An exit bit gives ram_vld_x0/x1 in the cycle the RAM data is valid: re at cycle N -> valid at N+RD_LAT.
//   - Back-to-back re gives valid on every cycle.
// - Source select, x0 (cfg[1:0]): 00 x0 RAM, 01 x1 RAM, 10 forward_low_i, 11 forward_up_i.
// - Source select, x1 (cfg[3:2]): 00 x1 RAM, 01 x0 RAM, 10 forward_low_i, 11 forward_up_i.
//   - For a RAM source, data/valid = RAM rdata / ram_vld.
//   - For a forward source, data/valid = the neighbour pair.
//   - x0 and x1 selecting the same source is legal: both receive the same data (broadcast).
// - OUT_REG=1:
//   - x*_rvalid_o is the registered selected valid.
//   - x*_rdata_o loads only when the selected valid=1 and holds otherwise.
//   - Total latency is RD_LAT+1 from re.
// - OUT_REG=0: x*_rvalid_o and x*_rdata_o are combinational; latency is RD_LAT.
// - forward_*_o are never registered, so the cascade adds no per-hop latency:
//   - forward_up_o: cfg[5]=0 -> x0 RAM data with ram_vld_x0; cfg[5]=1 -> passthrough of forward_low_i pair.
//   - forward_low_o: cfg[4]=0 -> x0 RAM data with ram_vld_x0; cfg[4]=1 -> passthrough of forward_up_i pair.
// - Config shadow: cfg is registered every cycle.
//   - If cfg != shadow while any pipeline bit is 1 (or an output valid is 1), cfg_chg_err_o sets and stays 1 until reset.
//   - Routing always uses the current cfg.
// - Forward-source valids are not checked against local pipelines. A neighbour valid with no local request is passed as-is.
// TESTING
// - RD_LAT=2, OUT_REG=1, cfg=0x00:
//   - Stimulus: x0_ram_re_i pulse at cycle 10; x0_ram_rdata_i=0x12345 at cycle 12.
//   - Expect: x0_rvalid_o=1 at cycle 13 only, x0_rdata_o=0x12345 and holding afterwards.
// - cfg=0x05 (x0<-x1 RAM, x1<-x0 RAM), 4 back-to-back re on both ports:
//   - Expect: 4 consecutive valids on each port with swapped data, in order.
// - cfg=0x32 (x0<-low, fwd up/low passthrough):
//   - Stimulus: forward_rvalid_low_i=1 with data 0xABCDE.
//   - Expect: x0 gets 0xABCDE one cycle later; forward_up_o=0xABCDE/valid=1 in the same cycle.
// - cfg=0x00, fwd outputs local:
//   - Stimulus: x0_ram_re_i at cycle N.
//   - Expect: forward_rvalid_up_o and forward_rvalid_low_o =1 at N+RD_LAT carrying x0 RAM data.
// - Config error:
//   - Stimulus: re at cycle N, cfg changed 0x00->0x01 at N+1.
//   - Expect: cfg_chg_err_o=1 from N+2, sticky.
//   - Stimulus: the same cfg change with the pipeline empty.
//   - Expect: cfg_chg_err_o stays 0.
// - Reset mid-read:
//   - Stimulus: rst_i asserted at N+1 after re at N, RD_LAT=3.
//   - Expect: all outputs 0 immediately and no rvalid ever appears for that read.

Source files
------------

// File: rtl/forward_selection_rdata.sv
// forward_selection_rdata: read-data return path of the dpsram cascade.
// Tracks RAM read latency per port, steers local RAM or neighbour read data
// back to the port that issued the address, and drives the cascade neighbours.
module forward_selection_rdata #(
   parameter int unsigned DATA_W  = 20,
   parameter int unsigned RD_LAT  = 1,   // RAM read latency, 1..4
   parameter int unsigned OUT_REG = 1    // 1: registered x0/x1 outputs
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        cfg_forward_rdata_i,
   input  logic              x0_ram_re_i,
   input  logic              x1_ram_re_i,
   input  logic [DATA_W-1:0] x0_ram_rdata_i,
   input  logic [DATA_W-1:0] x1_ram_rdata_i,
   input  logic [DATA_W-1:0] forward_rdata_up_i,
   input  logic              forward_rvalid_up_i,
   input  logic [DATA_W-1:0] forward_rdata_low_i,
   input  logic              forward_rvalid_low_i,
   output logic [DATA_W-1:0] x0_rdata_o,
   output logic              x0_rvalid_o,
   output logic [DATA_W-1:0] x1_rdata_o,
   output logic              x1_rvalid_o,
   output logic [DATA_W-1:0] forward_rdata_up_o,
   output logic              forward_rvalid_up_o,
   output logic [DATA_W-1:0] forward_rdata_low_o,
   output logic              forward_rvalid_low_o,
   output logic              cfg_chg_err_o
);

   logic [RD_LAT-1:0] x0_pipe_q, x0_pipe_d;
   logic [RD_LAT-1:0] x1_pipe_q, x1_pipe_d;
   logic              ram_vld_x0, ram_vld_x1;
   logic [7:0]        cfg_q;
   logic              cfg_chg_err_q;
   logic              pending;
   logic [DATA_W-1:0] x0_sel_data, x1_sel_data;
   logic              x0_sel_vld, x1_sel_vld;

   if (RD_LAT == 1) begin : g_lat1
      assign x0_pipe_d = x0_ram_re_i;
      assign x1_pipe_d = x1_ram_re_i;
   end else begin : g_latn
      assign x0_pipe_d = {x0_pipe_q[RD_LAT-2:0], x0_ram_re_i};
      assign x1_pipe_d = {x1_pipe_q[RD_LAT-2:0], x1_ram_re_i};
   end

   // Exit bit marks the cycle in which the RAM data is valid
   assign ram_vld_x0 = x0_pipe_q[RD_LAT-1];
   assign ram_vld_x1 = x1_pipe_q[RD_LAT-1];

   // Read-enable shift registers and config shadow; reset drops in-flight reads
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x0_pipe_q <= '0;
         x1_pipe_q <= '0;
         cfg_q     <= '0;
      end else begin
         x0_pipe_q <= x0_pipe_d;
         x1_pipe_q <= x1_pipe_d;
         cfg_q     <= cfg_forward_rdata_i;
      end
   end

   // Any read still owed to a port makes a config change unsafe
   assign pending = (|x0_pipe_q) | (|x1_pipe_q) | x0_rvalid_o | x1_rvalid_o;

   // Sticky error: cfg moved while a read was in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cfg_chg_err_q <= 1'b0;
      end else if (pending && (cfg_forward_rdata_i != cfg_q)) begin
         cfg_chg_err_q <= 1'b1;
      end
   end

   assign cfg_chg_err_o = cfg_chg_err_q;

   // Source select per port; routing always follows the live cfg
   always_comb begin
      x0_sel_data = x0_ram_rdata_i;
      x0_sel_vld  = ram_vld_x0;
      unique case (cfg_forward_rdata_i[1:0])
         2'b00: begin x0_sel_data = x0_ram_rdata_i;      x0_sel_vld = ram_vld_x0;           end
         2'b01: begin x0_sel_data = x1_ram_rdata_i;      x0_sel_vld = ram_vld_x1;           end
         2'b10: begin x0_sel_data = forward_rdata_low_i; x0_sel_vld = forward_rvalid_low_i; end
         2'b11: begin x0_sel_data = forward_rdata_up_i;  x0_sel_vld = forward_rvalid_up_i;  end
         default: ;
      endcase
      x1_sel_data = x1_ram_rdata_i;
      x1_sel_vld  = ram_vld_x1;
      unique case (cfg_forward_rdata_i[3:2])
         2'b00: begin x1_sel_data = x1_ram_rdata_i;      x1_sel_vld = ram_vld_x1;           end
         2'b01: begin x1_sel_data = x0_ram_rdata_i;      x1_sel_vld = ram_vld_x0;           end
         2'b10: begin x1_sel_data = forward_rdata_low_i; x1_sel_vld = forward_rvalid_low_i; end
         2'b11: begin x1_sel_data = forward_rdata_up_i;  x1_sel_vld = forward_rvalid_up_i;  end
         default: ;
      endcase
   end

   // Cascade outputs stay combinational so each hop adds no latency; forced 0 in reset
   always_comb begin
      forward_rdata_up_o   = x0_ram_rdata_i;
      forward_rvalid_up_o  = ram_vld_x0;
      forward_rdata_low_o  = x0_ram_rdata_i;
      forward_rvalid_low_o = ram_vld_x0;
      if (cfg_forward_rdata_i[5]) begin
         forward_rdata_up_o  = forward_rdata_low_i;
         forward_rvalid_up_o = forward_rvalid_low_i;
      end
      if (cfg_forward_rdata_i[4]) begin
         forward_rdata_low_o  = forward_rdata_up_i;
         forward_rvalid_low_o = forward_rvalid_up_i;
      end
      if (rst_i) begin
         forward_rdata_up_o   = '0;
         forward_rvalid_up_o  = 1'b0;
         forward_rdata_low_o  = '0;
         forward_rvalid_low_o = 1'b0;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] x0_rdata_q, x1_rdata_q;
      logic              x0_rvalid_q, x1_rvalid_q;

      // Output stage: valid follows the selection, data holds until the next valid
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            x0_rdata_q  <= '0;
            x1_rdata_q  <= '0;
            x0_rvalid_q <= 1'b0;
            x1_rvalid_q <= 1'b0;
         end else begin
            x0_rvalid_q <= x0_sel_vld;
            x1_rvalid_q <= x1_sel_vld;
            if (x0_sel_vld) x0_rdata_q <= x0_sel_data;
            if (x1_sel_vld) x1_rdata_q <= x1_sel_data;
         end
      end

      assign x0_rdata_o  = x0_rdata_q;
      assign x0_rvalid_o = x0_rvalid_q;
      assign x1_rdata_o  = x1_rdata_q;
      assign x1_rvalid_o = x1_rvalid_q;
   end else begin : g_out_comb
      assign x0_rdata_o  = rst_i ? '0 : x0_sel_data;
      assign x0_rvalid_o = ~rst_i & x0_sel_vld;
      assign x1_rdata_o  = rst_i ? '0 : x1_sel_data;
      assign x1_rvalid_o = ~rst_i & x1_sel_vld;
   end

endmodule
